rect_painter: RTL
=================

# rect_painter

Parametrised rectangle rasteriser for the 160×120 VGA adapter path. On a start pulse it streams one pixel per clock (plot, x, y, colour) for a BOX_W×BOX_H rectangle anchored at a top-left coordinate. In move mode it first erases the previously drawn rectangle in a background colour. It replaces the fixed 3×3 box painter: size, coordinate widths, colour and screen bounds are generic, and it adds a start/busy/done handshake, erase-before-draw and off-screen clipping.

## Interface
Parameters:
- BOX_W, 3, rectangle width in pixels (≥1)
- BOX_H, 3, rectangle height in pixels (≥1)
- X_BITS, 8, x coordinate width
- Y_BITS, 7, y coordinate width
- COLOUR_BITS, 3, colour width
- SCREEN_W, 160, visible columns; x ≥ SCREEN_W is clipped
- SCREEN_H, 120, visible rows; y ≥ SCREEN_H is clipped

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = draw only, 1 = move (erase previous, then draw)
- box_x  in  X_BITS  top-left x of the new rectangle
- box_y  in  Y_BITS  top-left y of the new rectangle
- colour  in  COLOUR_BITS  foreground colour
- bg_colour  in  COLOUR_BITS  erase colour
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel
- plot  out  1  pixel write strobe to the VGA adapter
- x  out  X_BITS  pixel x
- y  out  Y_BITS  pixel y
- colour_out  out  COLOUR_BITS  pixel colour

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE, start=1:
  - Latch box_x, box_y, colour, bg_colour and mode.
  - If mode=1 and prev_valid=1, go to ERASE; otherwise go to DRAW.
- ERASE:
  - Raster the rectangle at the stored previous position (prev_x, prev_y) in bg_colour.
  - Scan is row-major: cx 0..BOX_W-1 inner, cy 0..BOX_H-1 outer.
  - On the last pixel, go to DRAW with the counters cleared.
- DRAW:
  - Raster the latched new position in the latched colour, same scan order.
  - On the last pixel: go to DONE, copy the latched position into prev_x/prev_y, set prev_valid.
- DONE: assert done for one cycle, then go to IDLE.
- Pixel arithmetic:
  - px = base_x + cx, computed X_BITS+1 wide; py = base_y + cy, computed Y_BITS+1 wide.
  - If px ≥ SCREEN_W or py ≥ SCREEN_H, plot=0 for that cycle. x and y still carry the truncated value and the cycle is still consumed, so the pixel count is constant.
- start while busy is ignored; there is no queuing.
- Input changes after acceptance have no effect until the next request.
- Reset values: all outputs 0, state IDLE, counters 0, prev_valid=0, prev_x=prev_y=0.

## Timing
- Accepting edge k (start=1 in IDLE): first pixel appears on outputs after edge k+1, and busy=1 from the same edge.
- All outputs are registered.
- Draw-only operation:
  - Pixels occupy cycles k+1 .. k+BOX_W·BOX_H.
  - done=1 in cycle k+BOX_W·BOX_H+1; busy falls with done.
  - A new start is accepted in the cycle after done.
- Move with prev_valid=1: ERASE pixels directly followed by DRAW pixels, no gap. Total 2·BOX_W·BOX_H pixel cycles, then done.
- Move with prev_valid=0: identical to draw-only.
- resetn=0 mid-operation:
  - Next edge returns to IDLE with all outputs 0.
  - prev_valid is cleared, so the next move does not erase.
  - No partial prev update.
- BOX_W=BOX_H=1: a single pixel cycle per phase; the last-pixel flag is asserted on the first pixel.

## Structure
- Package painter_pkg holds:
  - state enum (IDLE, ERASE, DRAW, DONE)
  - default SCREEN_W/SCREEN_H
  - default coordinate and colour widths
- Sub-module rect_scanner:
  - Parametrised on BOX_W/BOX_H.
  - Inputs clk, resetn, clear, advance.
  - Outputs cx, cy and a last flag (cx=BOX_W-1 and cy=BOX_H-1).
  - Counter widths are $clog2 of the box dimension, with a minimum of 1.
- The top level owns the FSM, latches, prev registers, clipping and output registers.

## Test plan
- Reset, then draw with defaults, box=(10,20), colour=3'b100:
  - 9 pixels with plot=1, in order (10,20),(11,20),(12,20),(10,21)…(12,22), colour_out=3'b100.
  - done pulses in cycle 10 after acceptance; busy is high cycles 1–10.
- Draw (10,20), then move to (50,60) with bg_colour=0:
  - 9 erase pixels at (10..12,20..22) with colour 0, immediately followed by 9 draw pixels at (50..52,60..62).
  - done after 18 pixel cycles.
- Clipping, box=(158,118), BOX_W=BOX_H=3:
  - Exactly 4 pixels with plot=1: (158,118),(159,118),(158,119),(159,119).
  - The other 5 cycles have plot=0; done is still at cycle 10.
- start held high throughout a 5×4 draw:
  - No re-trigger while busy; exactly 20 pixel cycles.
  - A second request is accepted in the cycle after done.
- resetn=0 for one cycle during the 4th draw pixel:
  - Outputs are 0 on the next edge.
  - A following move to (30,30) produces draw-only, 9 pixels with no erase.
- BOX_W=BOX_H=1, move sequence (5,5)→(6,6): erase (5,5) then draw (6,6); done two pixel cycles after acceptance.

Source files
------------

// File: rtl/painter_pkg.sv
// Shared types and defaults for the rectangle painter.
// The state enum, default screen geometry and widths, and the counter-width helper.
package painter_pkg;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam int DEF_SCREEN_W    = 160;
  localparam int DEF_SCREEN_H    = 120;
  localparam int DEF_X_BITS      = 8;
  localparam int DEF_Y_BITS      = 7;
  localparam int DEF_COLOUR_BITS = 3;

  // Counter width for a dimension of n pixels; a 1-pixel dimension still gets one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major cx/cy scan counter over a BOX_W x BOX_H box; last is combinational.
// Steps one position per advance; clear wins over advance. No backpressure.
module rect_scanner
  import painter_pkg::*;
#(
  parameter int BOX_W = 3,
  parameter int BOX_H = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       advance,
  output logic [cnt_bits(BOX_W)-1:0] cx,
  output logic [cnt_bits(BOX_H)-1:0] cy,
  output logic                       last
);

  localparam int CX_BITS = cnt_bits(BOX_W);
  localparam int CY_BITS = cnt_bits(BOX_H);
  localparam logic [CX_BITS-1:0] CX_MAX = CX_BITS'(BOX_W - 1);
  localparam logic [CY_BITS-1:0] CY_MAX = CY_BITS'(BOX_H - 1);

  logic cx_end;
  logic cy_end;

  assign cx_end = (cx == CX_MAX);
  assign cy_end = (cy == CY_MAX);
  assign last   = cx_end && cy_end;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      if (cx_end) begin
        cx <= '0;
        cy <= cy_end ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rect_painter.sv
// Rasterises a BOX_W x BOX_H rectangle one pixel per clock, optionally erasing the previous one first.
// First pixel one cycle after start is accepted; start is ignored while busy (no queuing).
module rect_painter
  import painter_pkg::*;
#(
  parameter int BOX_W       = 3,
  parameter int BOX_H       = 3,
  parameter int X_BITS      = DEF_X_BITS,
  parameter int Y_BITS      = DEF_Y_BITS,
  parameter int COLOUR_BITS = DEF_COLOUR_BITS,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   mode,
  input  logic [X_BITS-1:0]      box_x,
  input  logic [Y_BITS-1:0]      box_y,
  input  logic [COLOUR_BITS-1:0] colour,
  input  logic [COLOUR_BITS-1:0] bg_colour,
  output logic                   busy,
  output logic                   done,
  output logic                   plot,
  output logic [X_BITS-1:0]      x,
  output logic [Y_BITS-1:0]      y,
  output logic [COLOUR_BITS-1:0] colour_out
);

  localparam int CX_BITS = cnt_bits(BOX_W);
  localparam int CY_BITS = cnt_bits(BOX_H);

  state_t state, state_nxt;

  logic [X_BITS-1:0]      new_x, prev_x, base_x;
  logic [Y_BITS-1:0]      new_y, prev_y, base_y;
  logic [COLOUR_BITS-1:0] fg_col, bg_col, pix_col;
  logic                   prev_valid;

  logic [CX_BITS-1:0] cx;
  logic [CY_BITS-1:0] cy;
  logic               last;
  logic               accept;
  logic               scanning;

  logic [X_BITS:0] px;
  logic [Y_BITS:0] py;
  logic            in_view;

  logic                   busy_nxt, done_nxt, plot_nxt;
  logic [X_BITS-1:0]      x_nxt;
  logic [Y_BITS-1:0]      y_nxt;
  logic [COLOUR_BITS-1:0] col_nxt;

  assign accept   = (state == IDLE) && start;
  assign scanning = (state == ERASE) || (state == DRAW);

  // Counters restart on acceptance and again at the erase/draw boundary.
  rect_scanner #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_scanner (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept || ((state == ERASE) && last)),
    .advance (scanning),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (mode && prev_valid) ? ERASE : DRAW;
      ERASE:   if (last) state_nxt = DRAW;
      DRAW:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sums are one bit wider than the coordinate so off-screen wrap is still detected.
  always_comb begin
    base_x  = (state == ERASE) ? prev_x : new_x;
    base_y  = (state == ERASE) ? prev_y : new_y;
    pix_col = (state == ERASE) ? bg_col : fg_col;
    px      = {1'b0, base_x} + (X_BITS + 1)'(cx);
    py      = {1'b0, base_y} + (Y_BITS + 1)'(cy);
    in_view = (px < (X_BITS + 1)'(SCREEN_W)) && (py < (Y_BITS + 1)'(SCREEN_H));
  end

  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    plot_nxt = 1'b0;
    x_nxt    = '0;
    y_nxt    = '0;
    col_nxt  = '0;
    if (scanning) begin
      busy_nxt = 1'b1;
      plot_nxt = in_view;
      x_nxt    = px[X_BITS-1:0];
      y_nxt    = py[Y_BITS-1:0];
      col_nxt  = pix_col;
    end else if (state == DONE) begin
      busy_nxt = 1'b1;
      done_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
      new_x      <= '0;
      new_y      <= '0;
      fg_col     <= '0;
      bg_col     <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      prev_valid <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      done       <= done_nxt;
      plot       <= plot_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      colour_out <= col_nxt;
      if (accept) begin
        new_x  <= box_x;
        new_y  <= box_y;
        fg_col <= colour;
        bg_col <= bg_colour;
      end
      // Previous position only updates once the draw has fully completed.
      if ((state == DRAW) && last) begin
        prev_x     <= new_x;
        prev_y     <= new_y;
        prev_valid <= 1'b1;
      end
    end
  end

endmodule
